// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS main controller with memory handshake, wait-timeout fault and retire counter
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE  = 4'd1,  MEM_ADDR = 4'd2,  MEM_RD  = 4'd3,
    MEM_WB   = 4'd4,  MEM_WR  = 4'd5,  EXEC_R   = 4'd6,  R_WB    = 4'd7,
    BRANCH   = 4'd8,  JUMP    = 4'd9,  ADDI_EX  = 4'd10, ADDI_WB = 4'd11,
    TRAP     = 4'd12, FAULT   = 4'd13
  } state_t;
  state_t           state_q, state_d;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run, waiting, timeout, retire;
  assign run     = !RESET;
  assign waiting = (state_q inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready;
  assign timeout = waiting && (wait_q == 8'(WAIT_LIMIT - 1));
  assign retire  = (state_q inside {MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB}) || (state_q == MEM_WR && mem_ready);
  // next-state sequencing; a memory timeout preempts the normal transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE:   state_d = opcode == 6'd0  ? EXEC_R :
                          (opcode == 6'd35 || opcode == 6'd43) ? MEM_ADDR :
                          opcode == 6'd4  ? BRANCH :
                          opcode == 6'd2  ? JUMP :
                          opcode == 6'd8  ? ADDI_EX : TRAP;
      MEM_ADDR: state_d = opcode == 6'd35 ? MEM_RD : MEM_WR;
      MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
      EXEC_R:   state_d = R_WB;
      ADDI_EX:  state_d = ADDI_WB;
      FAULT:    state_d = FAULT;
      default:  state_d = FETCH;
    endcase
    if (timeout) state_d = FAULT;
  end
  // state, wait counter (cleared on any state change) and retired-instruction counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_d != state_q) ? 8'd0 : wait_q + {7'd0, waiting};
      cnt_q   <= cnt_q + CNT_W'(retire);
    end
  end
  assign mem_read    = run && (state_q == FETCH || state_q == MEM_RD);
  assign mem_write   = run && state_q == MEM_WR;
  assign iord        = run && (state_q == MEM_RD || state_q == MEM_WR);
  assign ir_write    = run && state_q == FETCH && mem_ready;
  assign pc_write    = run && ((state_q == FETCH && mem_ready) || state_q == JUMP || (state_q == BRANCH && zero));
  assign pc_source   = !run ? 2'd0 : state_q == BRANCH ? 2'd1 : state_q == JUMP ? 2'd2 : 2'd0;
  assign alu_src_a   = run && (state_q inside {MEM_ADDR, EXEC_R, BRANCH, ADDI_EX});
  assign alu_src_b   = !run ? 2'd0 : state_q == FETCH ? 2'd1 : state_q == DECODE ? 2'd3 :
                       (state_q == MEM_ADDR || state_q == ADDI_EX) ? 2'd2 : 2'd0;
  assign alu_op      = !run ? 2'd0 : state_q == EXEC_R ? 2'd2 : state_q == BRANCH ? 2'd1 : 2'd0;
  assign reg_dst     = run && state_q == R_WB;
  assign mem_to_reg  = run && state_q == MEM_WB;
  assign reg_write   = run && (state_q inside {MEM_WB, R_WB, ADDI_WB});
  assign illegal     = run && state_q == TRAP;
  assign fault       = run && state_q == FAULT;
  assign state       = run ? state_q : FETCH;
  assign instr_count = run ? cnt_q : '0;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed scenario bench for the multi-cycle controller
module tb_mips_multicycle_ctrl;
  localparam int WL = 4;
  localparam int CW = 4;
  logic          clk = 0, rst = 1, zero = 0, mem_ready = 1;
  logic [5:0]    opcode = 0;
  logic          mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0]    pc_source, alu_src_b, alu_op;
  logic          alu_src_a, reg_dst, mem_to_reg, reg_write, illegal, fault;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  int            vectors = 0, errors = 0;

  mips_multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .CLK(clk), .RESET(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .state(state), .illegal(illegal), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; mem_ready = 1; opcode = 0; zero = 0;
    tick; tick;
    @(negedge clk);
    vectors++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    vectors++; if (mem_read !== 1'b0 || pc_write !== 1'b0 || ir_write !== 1'b0) begin errors++; $display("FAIL reset_outputs got rd=%b pcw=%b irw=%b want 0", mem_read, pc_write, ir_write); end
    vectors++; if (fault !== 1'b0 || instr_count !== '0) begin errors++; $display("FAIL reset_regs got fault=%b cnt=%0d want 0/0", fault, instr_count); end
    tick;
    rst = 0;
  endtask

  task automatic test_add;
    int exp [4] = '{0, 1, 6, 7};
    opcode = 0; mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (state !== exp[i]) begin errors++; $display("FAIL add_state[%0d] got %0d want %0d", i, state, exp[i]); end
      vectors++; if (reg_write !== (exp[i] == 7) || reg_dst !== (exp[i] == 7)) begin errors++; $display("FAIL add_regwrite[%0d] got rw=%b rd=%b", i, reg_write, reg_dst); end
      vectors++; if (alu_op !== (exp[i] == 6 ? 2'd2 : 2'd0)) begin errors++; $display("FAIL add_aluop[%0d] got %0d", i, alu_op); end
      tick;
    end
    vectors++; if (state !== 4'd0 || instr_count !== 4'd1) begin errors++; $display("FAIL add_done got st=%0d cnt=%0d want 0/1", state, instr_count); end
  endtask

  task automatic test_lw_wait;
    int   exp [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    logic rdy [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    opcode = 35;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++; if (state !== exp[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp[i]); end
      vectors++; if (mem_read !== (exp[i] == 0 || exp[i] == 3) || iord !== (exp[i] == 3) || mem_write !== 1'b0) begin errors++; $display("FAIL lw_mem[%0d] got rd=%b iord=%b wr=%b", i, mem_read, iord, mem_write); end
      vectors++; if (reg_write !== (exp[i] == 4) || mem_to_reg !== (exp[i] == 4)) begin errors++; $display("FAIL lw_wb[%0d] got rw=%b m2r=%b", i, reg_write, mem_to_reg); end
      tick;
    end
    mem_ready = 1;
    vectors++; if (state !== 4'd0 || instr_count !== 4'd2 || fault !== 1'b0) begin errors++; $display("FAIL lw_done got st=%0d cnt=%0d fault=%b want 0/2/0", state, instr_count, fault); end
  endtask

  task automatic test_beq;
    int exp [3] = '{0, 1, 8};
    opcode = 4; mem_ready = 1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        vectors++; if (state !== exp[i]) begin errors++; $display("FAIL beq%0d_state[%0d] got %0d want %0d", z, i, state, exp[i]); end
        vectors++; if (pc_write !== (exp[i] == 0 || (exp[i] == 8 && z == 1))) begin errors++; $display("FAIL beq%0d_pcwrite[%0d] got %b", z, i, pc_write); end
        vectors++; if (pc_source !== (exp[i] == 8 ? 2'd1 : 2'd0) || alu_op !== (exp[i] == 8 ? 2'd1 : 2'd0)) begin errors++; $display("FAIL beq%0d_sel[%0d] got src=%0d op=%0d", z, i, pc_source, alu_op); end
        tick;
      end
      vectors++; if (state !== 4'd0 || instr_count !== 4'(4 - z)) begin errors++; $display("FAIL beq%0d_done got st=%0d cnt=%0d want 0/%0d", z, state, instr_count, 4 - z); end
    end
    zero = 0;
  endtask

  task automatic test_trap;
    int exp [3] = '{0, 1, 12};
    opcode = 63; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (state !== exp[i]) begin errors++; $display("FAIL trap_state[%0d] got %0d want %0d", i, state, exp[i]); end
      vectors++; if (illegal !== (exp[i] == 12)) begin errors++; $display("FAIL trap_illegal[%0d] got %b", i, illegal); end
      vectors++; if (reg_write !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL trap_nowrite[%0d] got rw=%b mw=%b", i, reg_write, mem_write); end
      tick;
    end
    vectors++; if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 4'd4) begin errors++; $display("FAIL trap_done got st=%0d ill=%b cnt=%0d want 0/0/4", state, illegal, instr_count); end
  endtask

  task automatic test_other_instrs;
    logic [5:0] ops [3] = '{43, 2, 8};
    int         len [3] = '{4, 3, 4};
    int         seq [3][4] = '{'{0, 1, 2, 5}, '{0, 1, 9, 0}, '{0, 1, 10, 11}};
    mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      for (int i = 0; i < len[k]; i++) begin
        int e;
        e = seq[k][i];
        @(negedge clk);
        vectors++; if (state !== e) begin errors++; $display("FAIL op%0d_state[%0d] got %0d want %0d", ops[k], i, state, e); end
        vectors++; if (mem_write !== (e == 5) || mem_read !== (e == 0) || reg_write !== (e == 11)) begin errors++; $display("FAIL op%0d_ctl[%0d] got mw=%b mr=%b rw=%b", ops[k], i, mem_write, mem_read, reg_write); end
        vectors++; if (pc_write !== (e == 0 || e == 9) || pc_source !== (e == 9 ? 2'd2 : 2'd0)) begin errors++; $display("FAIL op%0d_pc[%0d] got pcw=%b src=%0d", ops[k], i, pc_write, pc_source); end
        vectors++; if (alu_src_b !== (e == 0 ? 2'd1 : e == 1 ? 2'd3 : (e == 2 || e == 10) ? 2'd2 : 2'd0)) begin errors++; $display("FAIL op%0d_srcb[%0d] got %0d", ops[k], i, alu_src_b); end
        tick;
      end
      vectors++; if (state !== 4'd0 || instr_count !== 4'(5 + k)) begin errors++; $display("FAIL op%0d_done got st=%0d cnt=%0d want 0/%0d", ops[k], state, instr_count, 5 + k); end
    end
  endtask

  task automatic test_fault;
    rst = 1; tick; rst = 0;
    opcode = 0; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (state !== 4'd0 || mem_read !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL fault_wait[%0d] got st=%0d rd=%b fault=%b", i, state, mem_read, fault); end
      tick;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++; if (state !== 4'd13 || fault !== 1'b1 || mem_read !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL fault_hold[%0d] got st=%0d fault=%b rd=%b pcw=%b", i, state, fault, mem_read, pc_write); end
      tick;
      mem_ready = i[0];
    end
    rst = 1;
    @(negedge clk);
    vectors++; if (fault !== 1'b0 || state !== 4'd0) begin errors++; $display("FAIL fault_in_reset got fault=%b st=%0d", fault, state); end
    tick;
    rst = 0; mem_ready = 1;
    @(negedge clk);
    vectors++; if (state !== 4'd0 || fault !== 1'b0 || mem_read !== 1'b1) begin errors++; $display("FAIL fault_cleared got st=%0d fault=%b rd=%b", state, fault, mem_read); end
    tick;
  endtask

  task automatic test_wrap_and_abort;
    rst = 1; tick; rst = 0;
    opcode = 0; mem_ready = 1;
    for (int i = 0; i < 68; i++) tick;
    vectors++; if (state !== 4'd0 || instr_count !== 4'd1) begin errors++; $display("FAIL wrap got st=%0d cnt=%0d want 0/1", state, instr_count); end
    tick; tick;
    vectors++; if (state !== 4'd6) begin errors++; $display("FAIL abort_exec got %0d want 6", state); end
    rst = 1;
    @(negedge clk);
    vectors++; if (reg_write !== 1'b0 || state !== 4'd0) begin errors++; $display("FAIL abort_reset got rw=%b st=%0d", reg_write, state); end
    tick;
    rst = 0;
    @(negedge clk);
    vectors++; if (state !== 4'd0 || reg_write !== 1'b0 || instr_count !== 4'd0) begin errors++; $display("FAIL abort_fetch got st=%0d rw=%b cnt=%0d", state, reg_write, instr_count); end
    tick;
    @(negedge clk);
    vectors++; if (state !== 4'd1 || reg_write !== 1'b0) begin errors++; $display("FAIL abort_decode got st=%0d rw=%b", state, reg_write); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_lw_wait;
    test_beq;
    test_trap;
    test_other_instrs;
    test_fault;
    test_wrap_and_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle main controller for the MIPS ALU datapath. It replaces the combinational opcode decoder with a sequencing FSM covering fetch, decode, execute, memory and write-back.
- Drives the mux selects, PC and IR write enables, register-file write and the 2-bit ALUOp consumed by the ALU controller.
- Owns a req/ready handshake to the unified instruction/data memory, a wait-timeout fault, and a retired-instruction counter.

Parameters:
- WAIT_LIMIT, 16: maximum cycles a memory state waits for mem_ready before entering FAULT. Legal range 1..255.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- mem_read  out  1  memory read request, level, held until ready.
- mem_write  out  1  memory write request, level, held until ready.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  latch memory data into IR.
- pc_write  out  1  PC load enable.
- pc_source  out  2  PC input select: 0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 0 = B register, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left by 2.
- alu_op  out  2  ALUOp: 00 = add, 01 = subtract, 10 = decode funct.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register-file write enable.
- state  out  4  current state encoding, for debug.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- fault  out  1  sticky memory-timeout flag.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, TRAP 12, FAULT 13.
- All outputs are Moore, decoded from state, except these qualified signals:
  - ir_write and pc_write in FETCH are qualified by mem_ready.
  - pc_write in BRANCH is qualified by zero.
- Any control output not listed for a state is 0.
- While RESET is high:
  - state = FETCH, all outputs 0, wait counter = 0, fault = 0, instr_count = 0.
  - RESET overrides every other event, including mid-instruction and in FAULT.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_source=0.
  - When mem_ready=1: ir_write=1 and pc_write=1, next state DECODE.
  - Otherwise the state is held.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_op=00 (precomputes the branch target).
  - Next state by opcode: 0 → EXEC_R; 35 or 43 → MEM_ADDR; 4 → BRANCH; 2 → JUMP; 8 → ADDI_EX; any other → TRAP.
- MEM_ADDR:
  - Drives alu_src_a=1, alu_src_b=2, alu_op=00.
  - Next state: MEM_RD if opcode=35, MEM_WR if opcode=43.
- MEM_RD:
  - Drives mem_read=1, iord=1.
  - Advances to MEM_WB on mem_ready, otherwise holds.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
- MEM_WR:
  - Drives mem_write=1, iord=1.
  - Advances to FETCH on mem_ready, otherwise holds.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10; next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=0, alu_op=01, pc_source=1.
  - pc_write = zero. Next state FETCH.
- JUMP: pc_write=1, pc_source=2; next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=2, alu_op=00; next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
- TRAP:
  - illegal=1 for exactly one cycle; next state FETCH.
  - No register or memory write occurs for the trapped instruction.
  - The trapped instruction is not counted in instr_count.
- Wait counter:
  - 8-bit, cleared on every state change.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - If mem_ready=0 while the count equals WAIT_LIMIT-1: next state FAULT, fault=1.
  - mem_ready=1 on that same cycle wins: the state advances normally.
- FAULT:
  - All request and enable outputs are 0; fault stays 1.
  - Exited only by RESET.
- instr_count:
  - Increments by 1 on the final cycle of each instruction: MEM_WB, MEM_WR with mem_ready, R_WB, BRANCH, JUMP, ADDI_WB.
  - Wraps modulo 2^CNT_W.
- Latency with zero-wait memory, in cycles: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 3.
- mem_read and mem_write are never asserted in the same cycle.

Test Plan:
- Reset, then ADD (opcode 0) with mem_ready tied high → states 0, 1, 6, 7, 0; reg_write=1 and reg_dst=1 only in state 7; alu_op=10 in state 6; instr_count=1.
- lw (opcode 35), mem_ready low for 3 cycles in MEM_RD → mem_read and iord held high for 4 cycles; MEM_WB shows mem_to_reg=1 and reg_write=1; total 8 cycles.
- beq (opcode 4): zero=1 → pc_write=1 and pc_source=1 in state 8; repeat with zero=0 → pc_write=0; both return to FETCH after 3 cycles.
- Opcode 63 → TRAP entered, illegal pulses for exactly 1 cycle, no reg_write, instr_count unchanged, next state FETCH.
- WAIT_LIMIT=4, mem_ready held low in FETCH → FAULT entered after 4 cycles, fault=1 and mem_read=0, held for 20 cycles; RESET for 1 cycle → state 0, fault=0.
- CNT_W=4, run 17 zero-wait R-type instructions → instr_count=1; assert RESET during EXEC_R → next state FETCH, no reg_write pulse.
